l1a_event_tagger: RTL and testbench

- Parametrised L1A source and event-tag buffer for the ETROC readout path; next-generation replacement for the ad-hoc BCID counter, L1 counter and on-chip L1A logic.
- Selects the L1A source (external, periodic or pseudo-random), maintains a wrapping BCID counter and an L1 counter, and queues one tag {type, L1Count, BCID} per accepted L1A.
- The frame builder / readout controller drains the queue through a show-ahead valid/read handshake.

---
 rtl/l1a_event_tagger_if.sv | 23 ++
 rtl/l1a_event_tagger.sv | 191 +++++++++++++++++++
 tb/tb_l1a_event_tagger.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/l1a_event_tagger_if.sv
// Readout handshake between the tag buffer and its consumer.
// Show-ahead: the head tag is valid whenever outValid is high and is
// removed on a clock where rdEn and outValid are both high.
interface l1a_event_tagger_if #(
    parameter int BCID_WIDTH  = 12,
    parameter int L1CNT_WIDTH = 8
);
    logic                   rdEn;
    logic                   outValid;
    logic [1:0]             outType;
    logic [L1CNT_WIDTH-1:0] outL1Count;
    logic [BCID_WIDTH-1:0]  outBCID;

    modport master (
        input  rdEn,
        output outValid, outType, outL1Count, outBCID
    );

    modport slave (
        output rdEn,
        input  outValid, outType, outL1Count, outBCID
    );
endinterface

// File: rtl/l1a_event_tagger.sv
// L1A source selection (external / periodic / pseudo-random), wrapping BCID
// counter, L1 counter and a small tag FIFO drained through a show-ahead
// valid/read handshake.
module l1a_event_tagger #(
    parameter int BCID_WIDTH   = 12,
    parameter int BCID_MAX     = 3563,
    parameter int L1CNT_WIDTH  = 8,
    parameter int ADDRWIDTH    = 3,
    parameter int PERIOD_WIDTH = 12,
    parameter int RAND_BITS    = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dis,
    input  logic [1:0]              l1aConf,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    inL1A,
    input  logic                    BCIDRst,
    input  logic [BCID_WIDTH-1:0]   BCIDoffset,
    input  logic                    L1A_Rst,
    output logic                    actualL1A,
    output logic [BCID_WIDTH-1:0]   curBCID,
    output logic                    fifoFull,
    output logic                    fifoHalfFull,
    output logic                    overflow,
    output logic [7:0]              overflowCount,
    l1a_event_tagger_if.master      rd_if
);
    localparam int DEPTH = 1 << ADDRWIDTH;
    localparam int TAG_W = 2 + L1CNT_WIDTH + BCID_WIDTH;
    localparam logic [BCID_WIDTH-1:0] BCID_LAST = BCID_WIDTH'(BCID_MAX);
    localparam logic [ADDRWIDTH:0]    OCC_FULL  = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH:0]    OCC_HALF  = (ADDRWIDTH+1)'(DEPTH / 2);
    localparam logic [15:0]           LFSR_SEED = 16'hACE1;

    logic [15:0]             lfsr_q, lfsr_d;
    logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [BCID_WIDTH-1:0]   bcid_q, bcid_d;
    logic [L1CNT_WIDTH-1:0]  l1cnt_q, l1cnt_d;
    logic [ADDRWIDTH-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTH:0]      occ_q, occ_d;
    logic                    valid_q, valid_d, full_q, full_d, half_q, half_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              ovf_cnt_q, ovf_cnt_d;
    logic [TAG_W-1:0]        mem_q [DEPTH];

    logic                    mode_ext_s, mode_per_s, mode_rnd_s;
    logic                    per_pulse_s, rnd_pulse_s, src_pulse_s;
    logic [PERIOD_WIDTH-1:0] period_last_s;
    logic [1:0]              tag_type_s;
    logic                    occ_full_s, rd_en_s, wr_en_s, drop_s;

    assign mode_ext_s    = ~l1aConf[1];
    assign mode_per_s    = (l1aConf == 2'b10);
    assign mode_rnd_s    = (l1aConf == 2'b11);
    assign period_last_s = period - PERIOD_WIDTH'(1);
    assign per_pulse_s   = mode_per_s & (period != {PERIOD_WIDTH{1'b0}}) & (pcnt_q == period_last_s);
    assign rnd_pulse_s   = mode_rnd_s & (lfsr_q[RAND_BITS-1:0] == {RAND_BITS{1'b0}});

    // Mode-selected L1A pulse and the tag type recorded with it.
    always_comb begin
        src_pulse_s = 1'b0;
        tag_type_s  = 2'b00;
        case (l1aConf)
            2'b00, 2'b01: begin src_pulse_s = inL1A;       tag_type_s = 2'b00; end
            2'b10:        begin src_pulse_s = per_pulse_s; tag_type_s = 2'b10; end
            2'b11:        begin src_pulse_s = rnd_pulse_s; tag_type_s = 2'b01; end
            default:      begin src_pulse_s = 1'b0;        tag_type_s = 2'b00; end
        endcase
    end

    assign actualL1A = ~dis & src_pulse_s;

    // FIFO handshake decode: a pop needs data; a write when full only lands if a pop frees the slot.
    assign occ_full_s = (occ_q == OCC_FULL);
    assign rd_en_s    = rd_if.rdEn & (occ_q != {(ADDRWIDTH+1){1'b0}});
    assign wr_en_s    = actualL1A & (~occ_full_s | rd_en_s);
    assign drop_s     = actualL1A & occ_full_s & ~rd_en_s;

    // Next-state for generators, counters, FIFO bookkeeping and overflow tracking.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        // The period counter only runs in periodic mode, so any mode change restarts it from 0.
        if (dis || !mode_per_s || (period == {PERIOD_WIDTH{1'b0}})) begin
            pcnt_d = {PERIOD_WIDTH{1'b0}};
        end else if (pcnt_q >= period_last_s) begin
            pcnt_d = {PERIOD_WIDTH{1'b0}};
        end else begin
            pcnt_d = pcnt_q + PERIOD_WIDTH'(1);
        end

        if (dis) begin
            bcid_d = bcid_q;
        end else if (mode_ext_s && BCIDRst) begin
            bcid_d = (BCIDoffset > BCID_LAST) ? {BCID_WIDTH{1'b0}} : BCIDoffset;
        end else if (bcid_q >= BCID_LAST) begin
            bcid_d = {BCID_WIDTH{1'b0}};
        end else begin
            bcid_d = bcid_q + BCID_WIDTH'(1);
        end

        if (L1A_Rst) begin
            l1cnt_d = {L1CNT_WIDTH{1'b0}};
        end else if (actualL1A) begin
            l1cnt_d = l1cnt_q + L1CNT_WIDTH'(1);
        end else begin
            l1cnt_d = l1cnt_q;
        end

        if (dis) begin
            wr_ptr_d = {ADDRWIDTH{1'b0}};
            rd_ptr_d = {ADDRWIDTH{1'b0}};
            occ_d    = {(ADDRWIDTH+1){1'b0}};
        end else begin
            wr_ptr_d = wr_en_s ? (wr_ptr_q + ADDRWIDTH'(1)) : wr_ptr_q;
            rd_ptr_d = rd_en_s ? (rd_ptr_q + ADDRWIDTH'(1)) : rd_ptr_q;
            occ_d    = occ_q + (ADDRWIDTH+1)'(wr_en_s) - (ADDRWIDTH+1)'(rd_en_s);
        end

        // A drop in the same cycle as L1A_Rst survives the clear as a single count.
        if (L1A_Rst) begin
            ovf_d     = drop_s;
            ovf_cnt_d = drop_s ? 8'd1 : 8'd0;
        end else if (drop_s) begin
            ovf_d     = 1'b1;
            ovf_cnt_d = (ovf_cnt_q == 8'hFF) ? ovf_cnt_q : (ovf_cnt_q + 8'd1);
        end else begin
            ovf_d     = ovf_q;
            ovf_cnt_d = ovf_cnt_q;
        end

        valid_d = (occ_d != {(ADDRWIDTH+1){1'b0}});
        full_d  = (occ_d == OCC_FULL);
        half_d  = (occ_d >= OCC_HALF);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q    <= LFSR_SEED;
            pcnt_q    <= {PERIOD_WIDTH{1'b0}};
            bcid_q    <= {BCID_WIDTH{1'b0}};
            l1cnt_q   <= {L1CNT_WIDTH{1'b0}};
            wr_ptr_q  <= {ADDRWIDTH{1'b0}};
            rd_ptr_q  <= {ADDRWIDTH{1'b0}};
            occ_q     <= {(ADDRWIDTH+1){1'b0}};
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            half_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else begin
            lfsr_q    <= lfsr_d;
            pcnt_q    <= pcnt_d;
            bcid_q    <= bcid_d;
            l1cnt_q   <= l1cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            half_q    <= half_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Tag storage: {type, L1 count before increment, BCID before increment}.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {TAG_W{1'b0}};
            end
        end else if (wr_en_s && !dis) begin
            mem_q[wr_ptr_q] <= {tag_type_s, l1cnt_q, bcid_q};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign curBCID          = bcid_q;
    assign fifoFull         = full_q;
    assign fifoHalfFull     = half_q;
    assign overflow         = ovf_q;
    assign overflowCount    = ovf_cnt_q;
    assign rd_if.outValid   = valid_q;
    assign rd_if.outType    = mem_q[rd_ptr_q][TAG_W-1 -: 2];
    assign rd_if.outL1Count = mem_q[rd_ptr_q][BCID_WIDTH +: L1CNT_WIDTH];
    assign rd_if.outBCID    = mem_q[rd_ptr_q][BCID_WIDTH-1:0];
endmodule

// File: tb/tb_l1a_event_tagger.sv
// Scoreboard bench for l1a_event_tagger: the stimulus side predicts each
// accepted tag and queues it; a negedge monitor pops and compares on every
// consumer read.
module tb_l1a_event_tagger;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, dis, inL1A, BCIDRst, L1A_Rst;
    logic [1:0]  l1aConf;
    logic [11:0] period, BCIDoffset;
    logic        actualL1A, fifoFull, fifoHalfFull, overflow;
    logic [11:0] curBCID;
    logic [7:0]  overflowCount;

    l1a_event_tagger_if #(.BCID_WIDTH(12), .L1CNT_WIDTH(8)) rd_if ();

    l1a_event_tagger dut (
        .clk(clk), .reset(reset), .dis(dis), .l1aConf(l1aConf), .period(period),
        .inL1A(inL1A), .BCIDRst(BCIDRst), .BCIDoffset(BCIDoffset), .L1A_Rst(L1A_Rst),
        .actualL1A(actualL1A), .curBCID(curBCID), .fifoFull(fifoFull),
        .fifoHalfFull(fifoHalfFull), .overflow(overflow), .overflowCount(overflowCount),
        .rd_if(rd_if)
    );

    int errors = 0;
    int checks = 0;
    logic [21:0] exp_q [$];

    int m_bcid = 0, m_l1 = 0, m_pcnt = 0, m_occ = 0, m_ovf = 0, m_ovfcnt = 0;
    bit m_rand = 1'b0;
    int rnd_hits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] tag_type(input logic [1:0] conf);
        if (!conf[1])           return 2'b00;
        else if (conf == 2'b11) return 2'b01;
        else                    return 2'b10;
    endfunction

    // One clock: predict the L1A and FIFO effect, then advance the model.
    task automatic tick();
        bit fire, rd, acc, drop;
        @(negedge clk);
        fire = 1'b0; rd = 1'b0; acc = 1'b0; drop = 1'b0;
        if (m_rand) begin
            if (actualL1A) rnd_hits++;
        end else begin
            if (dis)                  fire = 1'b0;
            else if (!l1aConf[1])     fire = inL1A;
            else if (l1aConf == 2'b10) fire = (period != 12'd0) && (m_pcnt == int'(period) - 1);
            else                      fire = 1'b0;
            check("actualL1A", actualL1A, fire);
            rd   = rd_if.rdEn && (m_occ != 0);
            acc  = fire && ((m_occ < 8) || rd);
            drop = fire && (m_occ == 8) && !rd;
            if (acc) exp_q.push_back({tag_type(l1aConf), m_l1[7:0], m_bcid[11:0]});
        end
        @(posedge clk);
        #1;
        if (!m_rand) begin
            if (!dis) begin
                if (!l1aConf[1] && BCIDRst) m_bcid = (BCIDoffset > 12'd3563) ? 0 : int'(BCIDoffset);
                else                        m_bcid = (m_bcid == 3563) ? 0 : m_bcid + 1;
            end
            if (L1A_Rst)   m_l1 = 0;
            else if (fire) m_l1 = (m_l1 + 1) % 256;
            if (dis || l1aConf != 2'b10 || period == 12'd0) m_pcnt = 0;
            else if (m_pcnt == int'(period) - 1)           m_pcnt = 0;
            else                                          m_pcnt = m_pcnt + 1;
            if (dis) begin
                m_occ = 0;
                exp_q.delete();
            end else begin
                m_occ = m_occ + int'(acc) - int'(rd);
            end
            if (L1A_Rst) begin
                m_ovf = int'(drop); m_ovfcnt = int'(drop);
            end else if (drop) begin
                m_ovf = 1; m_ovfcnt = (m_ovfcnt == 255) ? 255 : m_ovfcnt + 1;
            end
        end
    endtask

    task automatic drain();
        rd_if.rdEn = 1'b1;
        for (int i = 0; i < 40 && rd_if.outValid; i++) tick();
        rd_if.rdEn = 1'b0;
        check("drain_empty", rd_if.outValid, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: compare the head tag whenever the consumer pops.
    always @(negedge clk) begin
        logic [21:0] e;
        if (reset === 1'b1 && rd_if.outValid === 1'b1 && rd_if.rdEn === 1'b1) begin
            if (m_rand) begin
                check("rand_type", rd_if.outType, 32'd1);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got a tag, expected none (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("tag_type", rd_if.outType, e[21:20]);
                check("tag_l1count", rd_if.outL1Count, e[19:12]);
                check("tag_bcid", rd_if.outBCID, e[11:0]);
            end
        end
    end

    initial begin
        reset = 1'b0; dis = 1'b0; inL1A = 1'b0; BCIDRst = 1'b0; L1A_Rst = 1'b0;
        l1aConf = 2'b00; period = 12'd0; BCIDoffset = 12'd0; rd_if.rdEn = 1'b0;
        #12;
        check("rst_outValid", rd_if.outValid, 32'd0);
        check("rst_fifoFull", fifoFull, 32'd0);
        check("rst_fifoHalfFull", fifoHalfFull, 32'd0);
        check("rst_overflow", overflow, 32'd0);
        check("rst_overflowCount", overflowCount, 32'd0);
        check("rst_curBCID", curBCID, 32'd0);
        check("rst_outType", rd_if.outType, 32'd0);
        check("rst_outL1Count", rd_if.outL1Count, 32'd0);
        check("rst_outBCID", rd_if.outBCID, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // External mode: BCID reset to offset 5, L1A when BCID reads 8.
        BCIDoffset = 12'd5; BCIDRst = 1'b1; tick(); BCIDRst = 1'b0;
        check("bcid_after_rst", curBCID, 32'd5);
        repeat (3) tick();
        check("bcid_before_l1a", curBCID, 32'd8);
        inL1A = 1'b1; tick(); inL1A = 1'b0;
        check("t1_valid_latency", rd_if.outValid, 32'd1);
        check("t1_head_type", rd_if.outType, 32'd0);
        check("t1_head_l1", rd_if.outL1Count, 32'd0);
        check("t1_head_bcid", rd_if.outBCID, 32'd8);
        drain();

        // BCID wrap: L1As at 3563 and at 0; out-of-range offset loads 0.
        BCIDoffset = 12'd3562; BCIDRst = 1'b1; tick(); BCIDRst = 1'b0;
        tick();
        check("bcid_at_max", curBCID, 32'd3563);
        inL1A = 1'b1; tick(); tick(); inL1A = 1'b0;
        check("bcid_after_wrap", curBCID, 32'd1);
        check("t2_head_l1", rd_if.outL1Count, 32'd1);
        check("t2_head_bcid", rd_if.outBCID, 32'd3563);
        BCIDoffset = 12'd4000; BCIDRst = 1'b1; tick(); BCIDRst = 1'b0;
        check("bcid_bad_offset", curBCID, 32'd0);
        drain();

        // Periodic, period 4: five tags over 20 clocks, L1 count restarted.
        L1A_Rst = 1'b1; tick(); L1A_Rst = 1'b0;
        l1aConf = 2'b10; period = 12'd4;
        repeat (15) tick();
        check("per_half_before", fifoHalfFull, 32'd0);
        tick();
        check("per_half_after4", fifoHalfFull, 32'd1);
        check("per_head_type", rd_if.outType, 32'd2);
        check("per_head_l1", rd_if.outL1Count, 32'd0);
        repeat (4) tick();
        check("per_not_full", fifoFull, 32'd0);
        period = 12'd1; repeat (3) tick();
        check("per1_full", fifoFull, 32'd1);
        period = 12'd0; repeat (3) tick();
        check("per0_no_overflow", overflow, 32'd0);

        // Overflow: two drops, then a write with a simultaneous pop while full.
        l1aConf = 2'b00; inL1A = 1'b1; repeat (2) tick();
        check("ovf_flag", overflow, 32'd1);
        check("ovf_count", overflowCount, 32'd2);
        rd_if.rdEn = 1'b1; tick(); rd_if.rdEn = 1'b0; inL1A = 1'b0;
        check("full_after_rdwr", fifoFull, 32'd1);
        check("ovf_count_kept", overflowCount, 32'd2);
        dis = 1'b1; tick(); dis = 1'b0;
        check("dis_valid", rd_if.outValid, 32'd0);
        check("dis_full", fifoFull, 32'd0);
        check("dis_ovf_kept", overflow, 32'd1);
        check("dis_ovfcnt_kept", overflowCount, 32'd2);

        // L1A_Rst clears overflow; count to 255, then L1A_Rst with a concurrent L1A.
        L1A_Rst = 1'b1; tick(); L1A_Rst = 1'b0;
        check("l1rst_ovf", overflow, 32'd0);
        check("l1rst_ovfcnt", overflowCount, 32'd0);
        rd_if.rdEn = 1'b1; inL1A = 1'b1;
        repeat (255) tick();
        L1A_Rst = 1'b1; tick(); L1A_Rst = 1'b0;
        tick();
        inL1A = 1'b0;
        drain();

        // Drop concurrent with L1A_Rst leaves a single counted overflow.
        inL1A = 1'b1; repeat (8) tick();
        L1A_Rst = 1'b1; tick(); L1A_Rst = 1'b0; inL1A = 1'b0;
        check("rst_drop_ovf", overflow, 32'd1);
        check("rst_drop_ovfcnt", overflowCount, 32'd1);
        drain();

        // Random mode over one full LFSR period.
        l1aConf = 2'b11; rd_if.rdEn = 1'b1; m_rand = 1'b1; rnd_hits = 0;
        repeat (65535) tick();
        checks++;
        if (rnd_hits < 922 || rnd_hits > 1126) begin
            errors++;
            $display("FAIL rand_rate: got %0d L1As expected 922..1126", rnd_hits);
        end
        rd_if.rdEn = 1'b0;
        for (int i = 0; i < 2000 && !rd_if.outValid; i++) tick();
        check("rand_burst_valid", rd_if.outValid, 32'd1);

        // Asynchronous reset mid-burst.
        #2 reset = 1'b0;
        #1;
        check("arst_outValid", rd_if.outValid, 32'd0);
        check("arst_fifoFull", fifoFull, 32'd0);
        check("arst_fifoHalfFull", fifoHalfFull, 32'd0);
        check("arst_overflow", overflow, 32'd0);
        check("arst_overflowCount", overflowCount, 32'd0);
        check("arst_curBCID", curBCID, 32'd0);
        check("arst_outType", rd_if.outType, 32'd0);
        check("arst_outL1Count", rd_if.outL1Count, 32'd0);
        check("arst_outBCID", rd_if.outBCID, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
